// File: rtl/hwag_spi_pkg.sv
// Shared types and frame-layout constants for the hwag SPI receive/transmit frame path.
package hwag_spi_pkg;

  typedef enum logic [1:0] {IDLE, RECV, EVAL} spi_rx_state_t;

  localparam int FRAME_OVERHEAD = 3;
  localparam int CMD_IDX        = 0;
  localparam int ADDR_IDX       = 1;
  localparam int DATA_IDX       = 2;

  function automatic int frame_bytes(input int data_bytes);
    return data_bytes + FRAME_OVERHEAD;
  endfunction

endpackage

// File: rtl/hwag_spi_byte_buffer.sv
// DEPTH x 8 byte register file with indexed write and flattened read-out (byte i at [8*i+:8]).
module hwag_spi_byte_buffer #(
  parameter int DEPTH = 7,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [IDX_W-1:0]   idx_i,
  input  logic [7:0]         wdata_i,
  output logic [8*DEPTH-1:0] rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign rdata_o[8*g +: 8] = mem_q[g];
  end

endmodule

// File: rtl/hwag_spi_rx_frame_param.sv
// SPI receive-frame capture: collects CMD/ADDR/DATA/CRC bytes while slave-select is low,
// checks length and CRC on its release, and commits good frames to a shadow register.
module hwag_spi_rx_frame_param
  import hwag_spi_pkg::*;
#(
  parameter int DATA_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    spi_ss,
  input  logic                    spi_rx,
  input  logic [7:0]              spi_bus_out,
  input  logic [7:0]              spi_crc_rx_out,
  output logic [7:0]              frame_cmd,
  output logic [7:0]              frame_addr,
  output logic [8*DATA_BYTES-1:0] frame_data,
  output logic                    frame_valid,
  output logic                    frame_crc_err,
  output logic                    frame_len_err,
  output logic                    busy
);

  localparam int FRAME_BYTES = frame_bytes(DATA_BYTES);
  localparam int CNT_W       = $clog2(FRAME_BYTES + 2);
  localparam int IDX_W       = $clog2(FRAME_BYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BYTES);

  spi_rx_state_t state_q, state_d;
  logic                    ss_q, ss_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic [7:0]              crc_calc_q, crc_calc_d;
  logic [7:0]              cmd_q, cmd_d, addr_q, addr_d;
  logic [8*DATA_BYTES-1:0] data_q, data_d;
  logic                    valid_q, valid_d, crc_err_q, crc_err_d, len_err_q, len_err_d;
  logic                    ss_fall, ss_rise, buf_we;
  logic [8*FRAME_BYTES-1:0] work;

  assign ss_fall = ~spi_ss & ss_q;
  assign ss_rise = spi_ss & ~ss_q;

  hwag_spi_byte_buffer #(.DEPTH(FRAME_BYTES)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .we_i    (buf_we),
    .idx_i   (cnt_q[IDX_W-1:0]),
    .wdata_i (spi_bus_out),
    .rdata_o (work)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    crc_calc_d = crc_calc_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    crc_err_d  = 1'b0;
    len_err_d  = 1'b0;
    buf_we     = 1'b0;
    // ss_q is frozen through EVAL so a fall arriving there is still seen once back in IDLE
    ss_d       = (state_q == EVAL) ? ss_q : spi_ss;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = RECV;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      RECV: begin
        if (ss_rise) begin
          state_d = EVAL;
        end else if (spi_rx && !spi_ss && !ovf_q) begin
          buf_we = (cnt_q < CNT_FULL);
          if (cnt_q == CNT_LAST) crc_calc_d = spi_crc_rx_out;
          if (cnt_q == CNT_FULL) ovf_d = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      EVAL: begin
        state_d = IDLE;
        if (cnt_q != CNT_FULL) begin
          len_err_d = 1'b1;
        end else if (work[8*(FRAME_BYTES-1) +: 8] == crc_calc_q) begin
          valid_d = 1'b1;
          cmd_d   = work[8*CMD_IDX +: 8];
          addr_d  = work[8*ADDR_IDX +: 8];
          data_d  = work[8*DATA_IDX +: 8*DATA_BYTES];
        end else begin
          crc_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ss_q       <= 1'b1;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      crc_calc_q <= '0;
      cmd_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      crc_err_q  <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ss_q       <= ss_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      crc_calc_q <= crc_calc_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      crc_err_q  <= crc_err_d;
      len_err_q  <= len_err_d;
    end
  end

  assign frame_cmd     = cmd_q;
  assign frame_addr    = addr_q;
  assign frame_data    = data_q;
  assign frame_valid   = valid_q;
  assign frame_crc_err = crc_err_q;
  assign frame_len_err = len_err_q;
  assign busy          = (state_q == RECV);

endmodule
